// File: rtl/apb2axi_pkg.sv
// Shared types and AXI encodings for the APB3-to-AXI4 bridge.
package apb2axi_pkg;

    // Bridge sequencing states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // EXOKAY is treated as success; SLVERR and DECERR report PSLVERR.
    function automatic logic resp_is_error(input logic [1:0] resp);
        case (resp)
            AXI_RESP_OKAY, AXI_RESP_EXOKAY: return 1'b0;
            default:                        return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/apb2axi32.sv
// APB3 slave to AXI4 master bridge: each APB access becomes one single-beat
// 32-bit AXI transaction, and the APB access is held in wait states until the
// AXI response returns.
//
// Handshake rules: a transfer happens on a rising ACLK edge where VALID and
// READY are both 1. VALID outputs are raised from registered state, are never
// withdrawn before their handshake, and the payload (address, data) stays
// stable while VALID is high. READY outputs are decoded from state only.
module apb2axi32
    import apb2axi_pkg::*;
#(
    parameter int                          AXI4_ADDRESS_WIDTH = 32,
    parameter int                          AXI4_ID_WIDTH      = 16,
    parameter int                          AXI4_USER_WIDTH    = 10,
    parameter int                          APB_ADDR_WIDTH     = 32,
    parameter logic [AXI4_ID_WIDTH-1:0]    AXI_ID             = '0,
    parameter logic [2:0]                  AXI_PROT           = 3'b000
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,

    // APB slave side
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0]     PADDR,
    input  logic [31:0]                   PWDATA,
    output logic [31:0]                   PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,

    // AXI write address
    output logic [AXI4_ID_WIDTH-1:0]      AWID,
    output logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR,
    output logic [7:0]                    AWLEN,
    output logic [2:0]                    AWSIZE,
    output logic [1:0]                    AWBURST,
    output logic                          AWLOCK,
    output logic [3:0]                    AWCACHE,
    output logic [2:0]                    AWPROT,
    output logic [3:0]                    AWREGION,
    output logic [3:0]                    AWQOS,
    output logic [AXI4_USER_WIDTH-1:0]    AWUSER,
    output logic                          AWVALID,
    input  logic                          AWREADY,

    // AXI write data
    output logic [31:0]                   WDATA,
    output logic [3:0]                    WSTRB,
    output logic                          WLAST,
    output logic [AXI4_USER_WIDTH-1:0]    WUSER,
    output logic                          WVALID,
    input  logic                          WREADY,

    // AXI write response
    input  logic [AXI4_ID_WIDTH-1:0]      BID,
    input  logic [1:0]                    BRESP,
    input  logic [AXI4_USER_WIDTH-1:0]    BUSER,
    input  logic                          BVALID,
    output logic                          BREADY,

    // AXI read address
    output logic [AXI4_ID_WIDTH-1:0]      ARID,
    output logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR,
    output logic [7:0]                    ARLEN,
    output logic [2:0]                    ARSIZE,
    output logic [1:0]                    ARBURST,
    output logic                          ARLOCK,
    output logic [3:0]                    ARCACHE,
    output logic [2:0]                    ARPROT,
    output logic [3:0]                    ARREGION,
    output logic [3:0]                    ARQOS,
    output logic [AXI4_USER_WIDTH-1:0]    ARUSER,
    output logic                          ARVALID,
    input  logic                          ARREADY,

    // AXI read data
    input  logic [AXI4_ID_WIDTH-1:0]      RID,
    input  logic [31:0]                   RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RLAST,
    input  logic [AXI4_USER_WIDTH-1:0]    RUSER,
    input  logic                          RVALID,
    output logic                          RREADY,

    // Debug view of the sequencer
    output state_e                        fsm_state
);

    logic [AXI4_ADDRESS_WIDTH-1:0] addr_q;
    logic [31:0]                   wdata_q;
    logic                          aw_done;
    logic                          w_done;
    logic                          aw_hs;
    logic                          w_hs;
    logic                          unused_inputs;

    // Single-beat, full-word, fixed-attribute transactions only.
    assign AWID     = AXI_ID;
    assign AWADDR   = addr_q;
    assign AWLEN    = 8'd0;
    assign AWSIZE   = AXI_SIZE_4B;
    assign AWBURST  = AXI_BURST_INCR;
    assign AWLOCK   = 1'b0;
    assign AWCACHE  = 4'd0;
    assign AWPROT   = AXI_PROT;
    assign AWREGION = 4'd0;
    assign AWQOS    = 4'd0;
    assign AWUSER   = '0;

    assign WDATA    = wdata_q;
    assign WSTRB    = 4'hF;
    assign WLAST    = 1'b1;
    assign WUSER    = '0;

    assign ARID     = AXI_ID;
    assign ARADDR   = addr_q;
    assign ARLEN    = 8'd0;
    assign ARSIZE   = AXI_SIZE_4B;
    assign ARBURST  = AXI_BURST_INCR;
    assign ARLOCK   = 1'b0;
    assign ARCACHE  = 4'd0;
    assign ARPROT   = AXI_PROT;
    assign ARREGION = 4'd0;
    assign ARQOS    = 4'd0;
    assign ARUSER   = '0;

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID & WREADY;

    // Response IDs, user bits and RLAST carry no information for single-beat
    // transactions issued with a constant ID.
    assign unused_inputs = ^{BID, BUSER, RID, RLAST, RUSER};

    // Sequencer: captures the APB setup phase, drives the AXI channels and
    // completes the APB access with a one-cycle PREADY.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            fsm_state <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            PRDATA    <= '0;
        end else begin
            PREADY <= 1'b0;
            case (fsm_state)
                IDLE: begin
                    // Only a genuine setup phase starts an access.
                    if (PSEL && !PENABLE) begin
                        addr_q  <= AXI4_ADDRESS_WIDTH'(PADDR);
                        wdata_q <= PWDATA;
                        if (PWRITE) begin
                            fsm_state <= WR_REQ;
                            AWVALID   <= 1'b1;
                            WVALID    <= 1'b1;
                        end else begin
                            fsm_state <= RD_REQ;
                            ARVALID   <= 1'b1;
                        end
                    end
                end

                WR_REQ: begin
                    // AW and W retire independently; leave once both have.
                    if (aw_hs) begin
                        AWVALID <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        WVALID <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        fsm_state <= WR_RESP;
                        BREADY    <= 1'b1;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                    end
                end

                WR_RESP: begin
                    if (BVALID) begin
                        fsm_state <= DONE;
                        BREADY    <= 1'b0;
                        PSLVERR   <= resp_is_error(BRESP);
                        PREADY    <= 1'b1;
                    end
                end

                RD_REQ: begin
                    if (ARREADY) begin
                        fsm_state <= RD_RESP;
                        ARVALID   <= 1'b0;
                        RREADY    <= 1'b1;
                    end
                end

                RD_RESP: begin
                    if (RVALID) begin
                        fsm_state <= DONE;
                        RREADY    <= 1'b0;
                        PRDATA    <= RDATA;
                        PSLVERR   <= resp_is_error(RRESP);
                        PREADY    <= 1'b1;
                    end
                end

                DONE: begin
                    fsm_state <= IDLE;
                end

                default: begin
                    fsm_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb2axi32.sv
// Self-checking bench for apb2axi32: an APB driver, a reactive AXI slave with
// programmable stalls and responses, and scoreboards for every channel.
module tb_apb2axi32;
    import apb2axi_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    logic [15:0] AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWLOCK, ARLOCK;
    logic [3:0]  AWCACHE, ARCACHE, AWREGION, ARREGION, AWQOS, ARQOS, WSTRB;
    logic [9:0]  AWUSER, ARUSER, WUSER, BUSER, RUSER;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST;
    logic        BVALID, BREADY, ARVALID, ARREADY;
    logic        RVALID, RREADY, RLAST;
    state_e      fsm_state;

    apb2axi32 dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWREGION(AWREGION),
        .AWQOS(AWQOS), .AWUSER(AWUSER), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WUSER(WUSER), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BUSER(BUSER), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARREGION(ARREGION),
        .ARQOS(ARQOS), .ARUSER(ARUSER), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RUSER(RUSER),
        .RVALID(RVALID), .RREADY(RREADY),
        .fsm_state(fsm_state)
    );

    // Clock
    always #5 ACLK = ~ACLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards
    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_w_q[$];
    logic [31:0] exp_ar_q[$];
    logic [32:0] exp_apb_q[$];   // {pslverr, prdata}
    logic [31:0] model_prdata;

    // AXI slave knobs
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  b_resp_knob = AXI_RESP_OKAY;
    logic [1:0]  r_resp_knob = AXI_RESP_OKAY;
    logic [31:0] r_data_knob = '0;
    int          w_beats = 0;

    // AXI slave: all drives and observations on the falling edge.
    int   aw_cyc, w_cyc, ar_cyc;
    logic aw_fire, w_fire, ar_fire, b_fire, r_fire;
    logic aw_got, w_got, ar_got;
    initial begin
        AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
        BID = '0; BRESP = '0; BUSER = '0; RID = '0; RDATA = '0; RRESP = '0;
        RLAST = 1'b1; RUSER = '0;
        aw_cyc = 0; w_cyc = 0; ar_cyc = 0;
        aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
                aw_cyc = 0; w_cyc = 0; ar_cyc = 0;
                aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
            end else begin
                if (b_fire) BVALID = 0;
                if (r_fire) RVALID = 0;
                if (aw_fire) aw_got = 1;
                if (w_fire)  w_got  = 1;
                if (ar_fire) ar_got = 1;
                if (aw_got && w_got && !BVALID) begin
                    BVALID = 1; BRESP = b_resp_knob; aw_got = 0; w_got = 0;
                end
                if (ar_got && !RVALID) begin
                    RVALID = 1; RDATA = r_data_knob; RRESP = r_resp_knob; ar_got = 0;
                end
                aw_cyc  = AWVALID ? aw_cyc + 1 : 0;
                w_cyc   = WVALID  ? w_cyc + 1  : 0;
                ar_cyc  = ARVALID ? ar_cyc + 1 : 0;
                AWREADY = AWVALID && (aw_cyc > aw_delay);
                WREADY  = WVALID  && (w_cyc > w_delay);
                ARREADY = ARVALID && (ar_cyc > ar_delay);
                aw_fire = AWVALID && AWREADY;
                w_fire  = WVALID && WREADY;
                ar_fire = ARVALID && ARREADY;
                b_fire  = BVALID && BREADY;
                r_fire  = RVALID && RREADY;

                // Address must match the expected value on every VALID cycle.
                if (AWVALID && exp_aw_q.size() > 0) check("awaddr", AWADDR, exp_aw_q[0]);
                if (ARVALID && exp_ar_q.size() > 0) check("araddr", ARADDR, exp_ar_q[0]);
                if (aw_fire && exp_aw_q.size() > 0) begin
                    void'(exp_aw_q.pop_front());
                    check("aw_fields", {AWID, AWLEN, 5'(AWSIZE), 6'(AWBURST), 3'(AWPROT), 1'(AWLOCK), AWCACHE, AWQOS, AWREGION},
                                       {16'h0, 8'h0, 5'd2, 6'd1, 3'd0, 1'b0, 4'h0, 4'h0, 4'h0});
                end
                if (ar_fire && exp_ar_q.size() > 0) begin
                    void'(exp_ar_q.pop_front());
                    check("ar_fields", {ARID, ARLEN, 5'(ARSIZE), 6'(ARBURST)}, {16'h0, 8'h0, 5'd2, 6'd1});
                end
                if (w_fire) begin
                    w_beats++;
                    if (exp_w_q.size() > 0) check("wdata", WDATA, exp_w_q.pop_front());
                    check("wstrb_wlast", {WSTRB, WLAST}, {4'hF, 1'b1});
                end
            end
        end
    end

    // APB completion monitor
    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESETn === 1'b1 && PREADY === 1'b1) begin
                if (exp_apb_q.size() == 0) begin
                    check("pready_unexpected", PREADY, 1'b0);
                end else begin
                    logic [32:0] e;
                    e = exp_apb_q.pop_front();
                    check("pslverr", PSLVERR, e[32]);
                    check("prdata", PRDATA, e[31:0]);
                end
            end
        end
    end

    function automatic logic resp_err_model(input logic [1:0] r);
        return (r == AXI_RESP_SLVERR) || (r == AXI_RESP_DECERR);
    endfunction

    // One APB access; checks the cycle count from setup to PREADY.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input int exp_lat);
        int lat;
        if (wr) begin
            exp_aw_q.push_back(addr);
            exp_w_q.push_back(data);
            exp_apb_q.push_back({resp_err_model(b_resp_knob), model_prdata});
        end else begin
            exp_ar_q.push_back(addr);
            model_prdata = r_data_knob;
            exp_apb_q.push_back({resp_err_model(r_resp_knob), r_data_knob});
        end
        @(negedge ACLK);
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = addr; PWDATA = data;
        @(negedge ACLK);
        PENABLE = 1;
        lat = 1;
        while (PREADY !== 1'b1 && lat < 100) begin
            @(negedge ACLK);
            lat++;
        end
        check("latency", lat, exp_lat);
        @(negedge ACLK);
        PSEL = 0; PENABLE = 0;
        check("pready_one_cycle", PREADY, 1'b0);
    endtask

    initial begin
        int wb;
        ARESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        model_prdata = '0;
        repeat (3) @(negedge ACLK);
        check("rst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 5'b0);
        check("rst_apb", {PREADY, PSLVERR, PRDATA}, 34'h0);
        check("rst_state", fsm_state, IDLE);
        ARESETn = 1;

        // Basic write and read, zero-wait
        apb_xfer(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 3);
        r_data_knob = 32'hCAFE_F00D;
        apb_xfer(1'b0, 32'h2000_0004, 32'h0, 3);

        // W accepted 3 cycles before AW
        aw_delay = 3; w_delay = 0; wb = w_beats;
        fork
            apb_xfer(1'b1, 32'h3000_0100, 32'h1234_5678, 6);
            begin
                repeat (3) @(negedge ACLK);
                check("wvalid_dropped", WVALID, 1'b0);
                check("awvalid_held", AWVALID, 1'b1);
            end
        join
        check("one_w_beat", w_beats - wb, 1);
        aw_delay = 0;

        // Error responses, then EXOKAY
        r_resp_knob = AXI_RESP_DECERR; r_data_knob = 32'h0BAD_0BAD;
        apb_xfer(1'b0, 32'h4000_0000, 32'h0, 3);
        b_resp_knob = AXI_RESP_SLVERR;
        apb_xfer(1'b1, 32'h4000_0004, 32'h5555_AAAA, 3);
        r_resp_knob = AXI_RESP_EXOKAY; r_data_knob = 32'h0000_600D;
        apb_xfer(1'b0, 32'h4000_0008, 32'h0, 3);
        b_resp_knob = AXI_RESP_OKAY; r_resp_knob = AXI_RESP_OKAY;

        // AR stalled 5 cycles
        ar_delay = 5; r_data_knob = 32'h7777_1111;
        apb_xfer(1'b0, 32'h5000_00F0, 32'h0, 8);
        ar_delay = 0;

        // Access phase without setup is ignored
        @(negedge ACLK);
        PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 32'h6000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("nosetup_awvalid", AWVALID, 1'b0);
            check("nosetup_state", fsm_state, IDLE);
        end
        PSEL = 0; PENABLE = 0;

        // Reset while stalled in WR_REQ
        aw_delay = 20; w_delay = 20;
        @(negedge ACLK);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h7000_0000; PWDATA = 32'hFFFF_0000;
        @(negedge ACLK);
        PENABLE = 1;
        @(negedge ACLK);
        check("pre_rst_state", fsm_state, WR_REQ);
        #2;
        ARESETn = 0; PSEL = 0; PENABLE = 0;
        #1;
        check("async_rst_outs", {AWVALID, WVALID, PREADY}, 3'b0);
        check("async_rst_state", fsm_state, IDLE);
        model_prdata = '0;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1; aw_delay = 0; w_delay = 0;
        apb_xfer(1'b1, 32'h7000_0040, 32'h0F0F_F0F0, 3);

        // Randomised mix
        for (int i = 0; i < 8; i++) begin
            logic wr;
            wr = 1'($urandom_range(0, 1));
            aw_delay = $urandom_range(0, 3);
            w_delay  = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3);
            b_resp_knob = 2'($urandom_range(0, 3));
            r_resp_knob = 2'($urandom_range(0, 3));
            r_data_knob = $urandom;
            apb_xfer(wr, $urandom, $urandom,
                     wr ? 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) : 3 + ar_delay);
        end

        repeat (3) @(negedge ACLK);
        check("queues_empty", exp_apb_q.size() + exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb2axi32.md
# apb2axi32

APB3 slave to AXI4 master bridge, the reverse of the team's AXI-to-APB bridge. It accepts one 32-bit APB read or write from a peripheral-side initiator and issues it as a single-beat AXI4 transaction. It waits for the AXI response and completes the APB access with the read data and error status. It sits where an APB-attached master, such as a debug or DMA-config port, must reach the SoC AXI interconnect.

## Interface
- AXI4_ADDRESS_WIDTH, 32, AXI address width; APB address zero-extended into it
- AXI4_ID_WIDTH, 16, width of AWID/ARID/BID/RID
- AXI4_USER_WIDTH, 10, width of AWUSER/WUSER/ARUSER (driven 0)
- APB_ADDR_WIDTH, 32, PADDR width; must be <= AXI4_ADDRESS_WIDTH
- AXI_ID, 0, constant ID placed on AWID/ARID
- AXI_PROT, 3'b000, constant AWPROT/ARPROT
- ACLK in 1: clock
- ARESETn in 1: reset, asynchronous, active-low
- PSEL, PENABLE, PWRITE in 1 each: APB control
- PADDR in APB_ADDR_WIDTH, PWDATA in 32: APB address/write data
- PRDATA out 32, PREADY out 1, PSLVERR out 1: APB response
- AW channel: AWID, AWADDR, AWLEN[7:0], AWSIZE[2:0], AWBURST[1:0], AWLOCK, AWCACHE[3:0], AWPROT[2:0], AWREGION[3:0], AWQOS[3:0], AWUSER out; AWVALID out; AWREADY in
- W channel: WDATA[31:0], WSTRB[3:0], WLAST, WUSER out; WVALID out; WREADY in
- B channel: BID, BRESP[1:0], BUSER in; BVALID in; BREADY out
- AR channel: same field set as AW, ARVALID out, ARREADY in
- R channel: RID, RDATA[31:0], RRESP[1:0], RLAST, RUSER in; RVALID in; RREADY out

## Operation
- Constant fields: AxLEN=0, AxSIZE=3'b010, AxBURST=INCR (2'b01), AxLOCK/AxCACHE/AxREGION/AxQOS/AxUSER=0, WSTRB=4'hF, WLAST=1, AxID=AXI_ID, AxPROT=AXI_PROT.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: on PSEL=1 and PENABLE=0 (setup phase), register PADDR, PWDATA and PWRITE. Next state is WR_REQ if PWRITE=1, else RD_REQ.
- WR_REQ: AWVALID and WVALID assert from the registered state. Each drops independently on its own handshake (per-channel done flags). Exit to WR_RESP once both have completed, including when both complete in the same cycle.
- WR_RESP: BREADY=1. On BVALID, capture PSLVERR=BRESP[1] and go to DONE.
- RD_REQ: ARVALID=1. On ARREADY, go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture PRDATA=RDATA and PSLVERR=RRESP[1], then go to DONE. RLAST and RID are ignored.
- Response mapping: EXOKAY maps to OKAY; SLVERR and DECERR set PSLVERR.
- DONE: PREADY=1 for exactly one cycle, then IDLE. PRDATA and PSLVERR hold their value until the next capture.
- PSEL deasserting mid-transaction does not abort it: the AXI transaction always completes and DONE is still visited.
- Writes with PENABLE already high in IDLE, i.e. no setup phase, are ignored.

## Timing
- Reset values: all AXI VALID/READY outputs 0, PREADY 0, PSLVERR 0, PRDATA 0, state IDLE.
- Reset mid-operation clears all of the above immediately. The AXI master may lose the in-flight transaction.
- All outputs are registered or decoded from state only. There is no combinational path from AXI inputs to APB outputs, or from APB inputs to AXI outputs.
- Zero-wait AXI timing:
  - Write: setup T0; AW/W handshake T1; B accepted T2; PREADY=1 at T3.
  - Read: setup T0; AR handshake T1; R accepted T2; PREADY=1 at T3.
- Minimum APB access latency is therefore 3 wait-extended cycles. Each AXI stall cycle adds one cycle.
- VALID is never dropped before its handshake, and payload fields are stable while VALID is high.

## Structure
- Package apb2axi_pkg: FSM state enum, AXI_BURST_INCR, AXI_RESP_* constants, AXI_SIZE_4B.
- Single module with no sub-module. The team's axi_*_buffer blocks may be placed externally if decoupling is needed.

## Test plan
- APB write 0x1000_0010 / 0xDEAD_BEEF with AWREADY=WREADY=1 and BRESP=OKAY -> AWADDR=0x1000_0010, WDATA=0xDEAD_BEEF, WSTRB=0xF; PREADY at T3; PSLVERR=0.
- APB read 0x2000_0004 with RDATA=0xCAFE_F00D and RRESP=OKAY -> ARLEN=0, ARSIZE=2; PRDATA=0xCAFE_F00D; PREADY for one cycle.
- Write with WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID holds; exactly one W beat; B accepted afterwards.
- Read returning RRESP=2'b11 (DECERR), then write returning BRESP=2'b10 (SLVERR) -> PSLVERR=1 on both. A following EXOKAY read -> PSLVERR=0.
- ARVALID stalled 5 cycles by ARREADY=0 -> ARADDR stable throughout; PREADY delayed by exactly 5 cycles.
- ARESETn pulsed low during WR_REQ -> AWVALID/WVALID/PREADY go 0 asynchronously; the next APB write completes normally.
